i2c_rom_sequencer: RTL and testbench

//  Microcode executor that consumes the 9-bit I2C command ROM (BME sensor init/readout scripts).
//  On start it fetches words from start_addr, decodes each word and issues byte-level commands
//  to the downstream I2C byte engine. Read bytes are streamed out with a running index.

---
 rtl/i2c_seq_pkg.sv | 27 ++
 rtl/i2c_rom_sequencer.sv | 207 ++++++++++++++++++++
 tb/tb_i2c_rom_sequencer.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/i2c_seq_pkg.sv
// Shared constants for the I2C ROM sequencer: ROM opcodes, byte-engine command codes, FSM states.
package i2c_seq_pkg;

    localparam logic [7:0] OP_END     = 8'h00;
    localparam logic [7:0] OP_START   = 8'h01;
    localparam logic [7:0] OP_STOP    = 8'h02;
    localparam logic [7:0] OP_RD_ACK  = 8'h03;
    localparam logic [7:0] OP_RD_NACK = 8'h04;
    localparam logic [7:0] OP_WAIT    = 8'h05;
    localparam logic [7:0] OP_JUMP    = 8'h06;

    localparam logic [2:0] CMD_START   = 3'd0;
    localparam logic [2:0] CMD_STOP    = 3'd1;
    localparam logic [2:0] CMD_WRITE   = 3'd2;
    localparam logic [2:0] CMD_RD_ACK  = 3'd3;
    localparam logic [2:0] CMD_RD_NACK = 3'd4;

    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_ROMW, S_DECODE, S_ISSUE, S_RSP, S_DELAY, S_DONE, S_ERR
    } state_t;

    // Which word the next DECODE interprets: an opcode or one of the operand words.
    typedef enum logic [1:0] {
        PH_OPC, PH_WAITN, PH_JHI, PH_JLO
    } phase_t;

endpackage

// File: rtl/i2c_rom_sequencer.sv
// Fetches 9-bit microcode words from the I2C command ROM and drives the byte engine
// through a valid/ready command port, streaming back read bytes with an index.
module i2c_rom_sequencer
    import i2c_seq_pkg::*;
#(
    parameter int AW      = 11,
    parameter int ROM_LAT = 1,
    parameter int DLY_W   = 16
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          start,
    input  logic [AW-1:0] start_addr,
    output logic [AW-1:0] rom_ad,
    output logic          rom_ce,
    output logic          rom_oce,
    input  logic [8:0]    rom_dout,
    output logic          cmd_valid,
    input  logic          cmd_ready,
    output logic [2:0]    cmd_op,
    output logic [7:0]    cmd_data,
    input  logic          rsp_valid,
    input  logic          rsp_nack,
    input  logic [7:0]    rsp_data,
    output logic          rd_valid,
    output logic [7:0]    rd_data,
    output logic [7:0]    rd_index,
    output logic          busy,
    output logic          done,
    output logic          error
);

    localparam logic [3:0] LAT_LOAD = 4'(ROM_LAT - 1);

    state_t           state;
    phase_t           phase;
    logic [AW-1:0]    pc;
    logic [8:0]       word;
    logic [3:0]       lat_cnt;
    logic [DLY_W-1:0] dly;
    logic [2:0]       jump_hi;
    logic             aborting;

    assign rom_ad  = pc;
    assign rom_oce = 1'b1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            phase     <= PH_OPC;
            pc        <= '0;
            word      <= '0;
            lat_cnt   <= '0;
            dly       <= '0;
            jump_hi   <= '0;
            aborting  <= 1'b0;
            rom_ce    <= 1'b0;
            cmd_valid <= 1'b0;
            cmd_op    <= '0;
            cmd_data  <= '0;
            rd_valid  <= 1'b0;
            rd_data   <= '0;
            rd_index  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
        end else begin
            rom_ce   <= 1'b0;
            rd_valid <= 1'b0;
            done     <= 1'b0;
            error    <= 1'b0;
            // Index advances the clock after each read pulse so the pulse carries the old value.
            if (rd_valid)
                rd_index <= rd_index + 8'd1;

            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        pc       <= start_addr;
                        phase    <= PH_OPC;
                        aborting <= 1'b0;
                        busy     <= 1'b1;
                        rd_index <= '0;
                        rom_ce   <= 1'b1;
                        state    <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    lat_cnt <= LAT_LOAD;
                    state   <= S_ROMW;
                end
                S_ROMW: begin
                    if (lat_cnt == 4'd0) begin
                        word  <= rom_dout;
                        state <= S_DECODE;
                    end else begin
                        lat_cnt <= lat_cnt - 4'd1;
                    end
                end
                S_DECODE: begin
                    unique case (phase)
                        PH_OPC: begin
                            if (word[8]) begin
                                cmd_valid <= 1'b1;
                                cmd_op    <= CMD_WRITE;
                                cmd_data  <= word[7:0];
                                state     <= S_ISSUE;
                            end else begin
                                unique case (word[7:0])
                                    OP_END: state <= S_DONE;
                                    OP_START, OP_STOP, OP_RD_ACK, OP_RD_NACK: begin
                                        cmd_valid <= 1'b1;
                                        cmd_data  <= 8'h00;
                                        cmd_op    <= (word[7:0] == OP_START)  ? CMD_START :
                                                     (word[7:0] == OP_STOP)   ? CMD_STOP  :
                                                     (word[7:0] == OP_RD_ACK) ? CMD_RD_ACK : CMD_RD_NACK;
                                        state     <= S_ISSUE;
                                    end
                                    OP_WAIT, OP_JUMP: begin
                                        phase  <= (word[7:0] == OP_WAIT) ? PH_WAITN : PH_JHI;
                                        pc     <= pc + AW'(1);
                                        rom_ce <= 1'b1;
                                        state  <= S_FETCH;
                                    end
                                    default: state <= S_ERR;
                                endcase
                            end
                        end
                        PH_WAITN: begin
                            phase <= PH_OPC;
                            if (word[7:0] == 8'h00) begin
                                pc     <= pc + AW'(1);
                                rom_ce <= 1'b1;
                                state  <= S_FETCH;
                            end else begin
                                dly   <= DLY_W'({word[7:0], 8'h00}) - DLY_W'(1);
                                state <= S_DELAY;
                            end
                        end
                        PH_JHI: begin
                            jump_hi <= word[2:0];
                            phase   <= PH_JLO;
                            pc      <= pc + AW'(1);
                            rom_ce  <= 1'b1;
                            state   <= S_FETCH;
                        end
                        default: begin
                            phase  <= PH_OPC;
                            pc     <= AW'({jump_hi, word[7:0]});
                            rom_ce <= 1'b1;
                            state  <= S_FETCH;
                        end
                    endcase
                end
                S_ISSUE: begin
                    if (cmd_ready) begin
                        cmd_valid <= 1'b0;
                        state     <= S_RSP;
                    end
                end
                S_RSP: begin
                    if (rsp_valid) begin
                        if (aborting) begin
                            state <= S_ERR;
                        end else if (cmd_op == CMD_WRITE && rsp_nack) begin
                            // Release the bus before reporting the failure.
                            aborting  <= 1'b1;
                            cmd_valid <= 1'b1;
                            cmd_op    <= CMD_STOP;
                            cmd_data  <= 8'h00;
                            state     <= S_ISSUE;
                        end else begin
                            if (cmd_op == CMD_RD_ACK || cmd_op == CMD_RD_NACK) begin
                                rd_valid <= 1'b1;
                                rd_data  <= rsp_data;
                            end
                            pc     <= pc + AW'(1);
                            rom_ce <= 1'b1;
                            state  <= S_FETCH;
                        end
                    end
                end
                S_DELAY: begin
                    if (dly == '0) begin
                        pc     <= pc + AW'(1);
                        rom_ce <= 1'b1;
                        state  <= S_FETCH;
                    end else begin
                        dly <= dly - DLY_W'(1);
                    end
                end
                S_DONE: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                S_ERR: begin
                    error <= 1'b1;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_rom_sequencer.sv
// Directed bench: behavioural ROM plus a byte-engine model with random ready and response delay.
module tb_i2c_rom_sequencer;
    import i2c_seq_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [10:0] start_addr = '0;
    logic [10:0] rom_ad;
    logic        rom_ce, rom_oce;
    logic [8:0]  rom_dout = '0;
    logic        cmd_valid;
    logic        cmd_ready = 1'b0;
    logic [2:0]  cmd_op;
    logic [7:0]  cmd_data;
    logic        rsp_valid = 1'b0;
    logic        rsp_nack = 1'b0;
    logic [7:0]  rsp_data = '0;
    logic        rd_valid;
    logic [7:0]  rd_data, rd_index;
    logic        busy, done, error;

    i2c_rom_sequencer #(.AW(11), .ROM_LAT(1), .DLY_W(16)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .start_addr(start_addr),
        .rom_ad(rom_ad), .rom_ce(rom_ce), .rom_oce(rom_oce), .rom_dout(rom_dout),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_nack(rsp_nack), .rsp_data(rsp_data),
        .rd_valid(rd_valid), .rd_data(rd_data), .rd_index(rd_index),
        .busy(busy), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    logic [8:0] mem [0:2047];
    int cyc = 0;
    always @(posedge clk) begin
        cyc = cyc + 1;
        if (rom_ce) rom_dout <= mem[rom_ad];
    end

    int total = 0;
    int bad = 0;
    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    logic [10:0] cmd_q[$];
    int          fetch_q[$];
    int          rdd_q[$];
    int          rdi_q[$];
    int          rsp_cyc_q[$];
    int          rise_cyc_q[$];
    logic [7:0]  rd_src[$];
    int          done_n, err_n, hold_viol;
    int          nack_byte = -1;
    logic        prev_valid = 1'b0, prev_ready = 1'b0;
    logic        pend = 1'b0, pend_nack = 1'b0;
    logic [7:0]  pend_data = '0;
    int          rsp_wait = 0;

    // Monitor and byte-engine model, all on the falling edge.
    always @(negedge clk) begin
        if (rom_ce) fetch_q.push_back(int'(rom_ad));
        if (rd_valid) begin
            rdd_q.push_back(int'(rd_data));
            rdi_q.push_back(int'(rd_index));
            $display("read data=%02h index=%0d", rd_data, rd_index);
        end
        if (done) done_n++;
        if (error) err_n++;
        if (reset_n && prev_valid && !prev_ready && !cmd_valid) hold_viol++;
        if (cmd_valid && !prev_valid) rise_cyc_q.push_back(cyc);
        prev_valid = cmd_valid;
        cmd_ready = 1'b0;
        rsp_valid = 1'b0;
        rsp_nack  = 1'b0;
        rsp_data  = 8'h00;
        if (!reset_n) begin
            pend = 1'b0;
        end else if (pend) begin
            if (rsp_wait == 0) begin
                rsp_valid = 1'b1;
                rsp_nack  = pend_nack;
                rsp_data  = pend_data;
                pend      = 1'b0;
                rsp_cyc_q.push_back(cyc);
            end else begin
                rsp_wait--;
            end
        end else if (cmd_valid && $urandom_range(0, 1) == 1) begin
            cmd_ready = 1'b1;
            cmd_q.push_back({cmd_op, cmd_data});
            $display("cmd op=%0d data=%02h", cmd_op, cmd_data);
            pend      = 1'b1;
            rsp_wait  = $urandom_range(0, 3);
            pend_nack = (cmd_op == CMD_WRITE) && (nack_byte == int'(cmd_data));
            pend_data = 8'h00;
            if ((cmd_op == CMD_RD_ACK || cmd_op == CMD_RD_NACK) && rd_src.size() > 0)
                pend_data = rd_src.pop_front();
        end
        prev_ready = cmd_ready;
    end

    task automatic load(input int addr, input logic [8:0] w[$]);
        foreach (w[i]) mem[(addr + i) % 2048] = w[i];
    endtask

    task automatic run(input logic [10:0] addr, input int budget, input int restart_at);
        cmd_q.delete(); fetch_q.delete(); rdd_q.delete(); rdi_q.delete();
        rsp_cyc_q.delete(); rise_cyc_q.delete();
        done_n = 0; err_n = 0; hold_viol = 0;
        @(negedge clk);
        start_addr = addr;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_start", int'(busy), 1);
        for (int i = 0; i < budget && done_n == 0 && err_n == 0; i++) begin
            start = (i == restart_at);
            if (i == restart_at) start_addr = 11'h100;
            @(negedge clk);
        end
        start = 1'b0;
        chk("finished_in_budget", int'((done_n + err_n) > 0), 1);
        repeat (4) @(negedge clk);
        chk("busy_after_end", int'(busy), 0);
        chk("hold_violations", hold_viol, 0);
    endtask

    task automatic cmp_cmds(input string tag, input logic [10:0] e[$]);
        chk({tag, "_count"}, cmd_q.size(), e.size());
        foreach (e[i])
            if (i < cmd_q.size()) chk($sformatf("%s_%0d", tag, i), int'(cmd_q[i]), int'(e[i]));
    endtask

    function automatic logic [10:0] c(input logic [2:0] op, input logic [7:0] d);
        return {op, d};
    endfunction

    int gap3, gap0;
    int waited;

    initial begin
        for (int i = 0; i < 2048; i++) mem[i] = 9'h000;
        mem[11'h100] = 9'h0FF;

        repeat (3) @(negedge clk);
        chk("rst_rom_oce", int'(rom_oce), 1);
        chk("rst_rom_ad", int'(rom_ad), 0);
        chk("rst_rom_ce", int'(rom_ce), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_cmd_valid", int'(cmd_valid), 0);
        chk("rst_rd_index", int'(rd_index), 0);
        chk("rst_done_error", int'({done, error}), 0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // Write-only script, with a second start mid-script that must be ignored.
        load(11'h010, '{9'h001, 9'h1EC, 9'h1F4, 9'h127, 9'h002, 9'h000});
        run(11'h010, 400, 8);
        cmp_cmds("t1", '{c(CMD_START, 0), c(CMD_WRITE, 8'hEC), c(CMD_WRITE, 8'hF4),
                         c(CMD_WRITE, 8'h27), c(CMD_STOP, 0)});
        chk("t1_done", done_n, 1);
        chk("t1_error", err_n, 0);
        chk("t1_fetches", fetch_q.size(), 6);
        if (fetch_q.size() > 0) chk("t1_first_fetch", fetch_q[0], 'h010);

        // Read script, twice so the index restart is visible.
        load(11'h040, '{9'h001, 9'h1ED, 9'h001, 9'h1EE, 9'h003, 9'h004, 9'h002, 9'h000});
        for (int r = 0; r < 2; r++) begin
            rd_src = '{8'h5A, 8'hA5};
            run(11'h040, 500, -1);
            cmp_cmds($sformatf("t2r%0d", r), '{c(CMD_START, 0), c(CMD_WRITE, 8'hED), c(CMD_START, 0),
                     c(CMD_WRITE, 8'hEE), c(CMD_RD_ACK, 0), c(CMD_RD_NACK, 0), c(CMD_STOP, 0)});
            chk("t2_reads", rdd_q.size(), 2);
            if (rdd_q.size() == 2) begin
                chk("t2_data0", rdd_q[0], 'h5A);
                chk("t2_data1", rdd_q[1], 'hA5);
                chk("t2_idx0", rdi_q[0], 0);
                chk("t2_idx1", rdi_q[1], 1);
            end
            chk("t2_index_end", int'(rd_index), 2);
        end

        // NACKed write: STOP then error, nothing fetched beyond the failing word.
        nack_byte = 'hEC;
        load(11'h080, '{9'h001, 9'h1EC, 9'h1F4, 9'h000});
        run(11'h080, 400, -1);
        nack_byte = -1;
        cmp_cmds("t3", '{c(CMD_START, 0), c(CMD_WRITE, 8'hEC), c(CMD_STOP, 0)});
        chk("t3_error", err_n, 1);
        chk("t3_done", done_n, 0);
        chk("t3_fetches", fetch_q.size(), 2);

        // WAIT n=3 versus n=0: rsp-to-next-cmd gap differs by exactly 768 clocks.
        load(11'h0A0, '{9'h001, 9'h005, 9'h003, 9'h002, 9'h000});
        run(11'h0A0, 1500, -1);
        chk("t4_rises3", rise_cyc_q.size(), 2);
        gap3 = (rise_cyc_q.size() > 1 && rsp_cyc_q.size() > 0) ? rise_cyc_q[1] - rsp_cyc_q[0] : -1;
        load(11'h0B0, '{9'h001, 9'h005, 9'h000, 9'h002, 9'h000});
        run(11'h0B0, 400, -1);
        chk("t4_rises0", rise_cyc_q.size(), 2);
        gap0 = (rise_cyc_q.size() > 1 && rsp_cyc_q.size() > 0) ? rise_cyc_q[1] - rsp_cyc_q[0] : -1;
        chk("t4_gap_n0", gap0, 10);
        chk("t4_gap_delta", gap3 - gap0, 768);

        // JUMP whose operands sit at the top of the ROM.
        load(11'h7FC, '{9'h001, 9'h006, 9'h000, 9'h020});
        load(11'h020, '{9'h002, 9'h000});
        run(11'h7FC, 400, -1);
        cmp_cmds("t5j", '{c(CMD_START, 0), c(CMD_STOP, 0)});
        chk("t5j_done", done_n, 1);
        chk("t5j_fetches", fetch_q.size(), 6);
        if (fetch_q.size() > 4) chk("t5j_target", fetch_q[4], 'h020);

        // Plain pc wrap 0x7FF -> 0x000.
        load(11'h7FE, '{9'h001, 9'h1AB, 9'h002, 9'h000});
        run(11'h7FE, 400, -1);
        cmp_cmds("t5w", '{c(CMD_START, 0), c(CMD_WRITE, 8'hAB), c(CMD_STOP, 0)});
        chk("t5w_done", done_n, 1);
        chk("t5w_error", err_n, 0);
        if (fetch_q.size() > 2) chk("t5w_wrap_fetch", fetch_q[2], 'h000);

        // Illegal opcode.
        load(11'h0C0, '{9'h001, 9'h0FF});
        run(11'h0C0, 400, -1);
        cmp_cmds("t5i", '{c(CMD_START, 0)});
        chk("t5i_error", err_n, 1);
        chk("t5i_done", done_n, 0);

        // Asynchronous reset while a command is pending.
        load(11'h0D0, '{9'h001, 9'h1EC, 9'h002, 9'h000});
        @(negedge clk);
        start_addr = 11'h0D0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        waited = 0;
        while (!cmd_valid && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        chk("t6_saw_cmd_valid", int'(cmd_valid), 1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("t6_cmd_valid", int'(cmd_valid), 0);
        chk("t6_busy", int'(busy), 0);
        chk("t6_rom_ce", int'(rom_ce), 0);
        chk("t6_rom_ad", int'(rom_ad), 0);
        chk("t6_rom_oce", int'(rom_oce), 1);
        chk("t6_cmd_op", int'(cmd_op), 0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        run(11'h010, 400, -1);
        cmp_cmds("t6", '{c(CMD_START, 0), c(CMD_WRITE, 8'hEC), c(CMD_WRITE, 8'hF4),
                         c(CMD_WRITE, 8'h27), c(CMD_STOP, 0)});
        chk("t6_done", done_n, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
